// File: rtl/hex_entry_pkg.sv
// Shared constants and types for the hex entry unit: din field split,
// command codes, FSM states and edit-buffer operations.
package hex_entry_pkg;

   localparam int DIN_W       = 5;
   localparam int DIN_CMD_BIT = 4;
   localparam int DIN_CODE_W  = 4;

   localparam logic [DIN_CODE_W-1:0] CMD_BKSP  = 4'd0;
   localparam logic [DIN_CODE_W-1:0] CMD_CLEAR = 4'd1;
   localparam logic [DIN_CODE_W-1:0] CMD_NEXT  = 4'd2;
   localparam logic [DIN_CODE_W-1:0] CMD_ENTER = 4'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RELEASE
   } state_t;

   typedef enum logic [2:0] {
      BUF_HOLD,
      BUF_SHIFT_IN,
      BUF_SHIFT_OUT,
      BUF_CLEAR,
      BUF_LOAD,
      BUF_CNT_CLR
   } buf_op_t;

   function automatic int sel_width(input int nreg);
      return (nreg < 2) ? 1 : $clog2(nreg);
   endfunction

endpackage

// File: rtl/hex_shift_buf.sv
// Shadow edit buffer with digit counter; shifts hex digits in/out, clears,
// loads, and drives the thermometer digit indicator.
module hex_shift_buf
   import hex_entry_pkg::*;
#(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   localparam int              NDIG    = WIDTH / 4,
   localparam int              CNTW    = $clog2(NDIG + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  buf_op_t          op,
   input  logic [3:0]       digit,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] buf_q,
   output logic [WIDTH-1:0] buf_nxt,
   output logic [NDIG-1:0]  blink
);

   logic [CNTW-1:0] cnt;
   logic [CNTW-1:0] cnt_nxt;

   always_comb begin
      buf_nxt = buf_q;
      cnt_nxt = cnt;
      case (op)
         BUF_SHIFT_IN: begin
            buf_nxt = {buf_q[WIDTH-5:0], digit};
            cnt_nxt = (cnt == CNTW'(NDIG)) ? cnt : cnt + 1'b1;
         end
         BUF_SHIFT_OUT: begin
            buf_nxt = buf_q >> 4;
            cnt_nxt = (cnt == '0) ? cnt : cnt - 1'b1;
         end
         BUF_CLEAR: begin
            buf_nxt = '0;
            cnt_nxt = '0;
         end
         BUF_LOAD: begin
            buf_nxt = load_val;
            cnt_nxt = '0;
         end
         BUF_CNT_CLR: cnt_nxt = '0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q <= RST_VAL;
         cnt   <= '0;
      end else begin
         buf_q <= buf_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      blink = '0;
      for (int i = 0; i < NDIG; i++) begin
         blink[i] = (CNTW'(i) < cnt);
      end
   end

endmodule

// File: rtl/hex_entry_bank.sv
// Multi-register hex entry unit: consumes scanner key codes and edits NREG
// operand registers through a shadow buffer. ENTRY_DIRECT_EN: edits write through.
//
// state     | meaning
// S_IDLE    | waiting for an enabled key
// S_EXEC    | applying the latched key (one cycle)
// S_RELEASE | holding readn low until the scanner drops din_valid
module hex_entry_bank
   import hex_entry_pkg::*;
#(
   parameter int               WIDTH   = 32,
   parameter int               NREG    = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   localparam int              NDIG    = WIDTH / 4,
   localparam int              SELW    = sel_width(NREG)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  edit_en,
   input  logic                  din_valid,
   input  logic [DIN_W-1:0]      din,
   output logic                  readn,
   output logic [NREG*WIDTH-1:0] regs,
   output logic [SELW-1:0]       sel,
   output logic [WIDTH-1:0]      edit_buf,
   output logic [NDIG-1:0]       blink,
   output logic                  commit
);

`ifdef ENTRY_DIRECT_EN
   localparam bit DIRECT_MODE = 1'b1;
`else
   localparam bit DIRECT_MODE = 1'b0;
`endif

   state_t           state;
   state_t           state_nxt;
   logic [DIN_W-1:0] key_q;
   logic [WIDTH-1:0] reg_q [NREG];
   logic [WIDTH-1:0] buf_nxt;
   logic [SELW-1:0]  sel_nxt;
   buf_op_t          buf_op;
   logic             reg_wr;
   logic             sel_adv;
   logic             accept;

   assign accept = (state == S_IDLE) && din_valid && edit_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      readn     = 1'b1;
      case (state)
         S_IDLE: begin
            if (din_valid && edit_en) state_nxt = S_EXEC;
         end
         S_EXEC: begin
            readn     = 1'b0;
            state_nxt = S_RELEASE;
         end
         S_RELEASE: begin
            readn = 1'b0;
            if (!din_valid) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Latch the key on acceptance so a scanner change mid-key cannot alter it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         key_q <= '0;
      else if (accept) key_q <= din;
   end

   assign sel_nxt = (sel == SELW'(NREG - 1)) ? '0 : sel + 1'b1;

   always_comb begin
      buf_op  = BUF_HOLD;
      reg_wr  = 1'b0;
      sel_adv = 1'b0;
      if (state == S_EXEC) begin
         if (!key_q[DIN_CMD_BIT]) begin
            buf_op = BUF_SHIFT_IN;
            reg_wr = DIRECT_MODE;
         end else begin
            case (key_q[DIN_CODE_W-1:0])
               CMD_BKSP: begin
                  buf_op = BUF_SHIFT_OUT;
                  reg_wr = DIRECT_MODE;
               end
               CMD_CLEAR: begin
                  buf_op = BUF_CLEAR;
                  reg_wr = DIRECT_MODE;
               end
               CMD_NEXT: begin
                  buf_op  = BUF_LOAD;
                  sel_adv = 1'b1;
               end
               CMD_ENTER: begin
                  buf_op = BUF_CNT_CLR;
                  reg_wr = !DIRECT_MODE;
               end
               default: ;
            endcase
         end
      end
   end

   hex_shift_buf #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
   ) u_shift_buf (
      .clk      (clk),
      .rst      (rst),
      .op       (buf_op),
      .digit    (key_q[3:0]),
      .load_val (reg_q[sel_nxt]),
      .buf_q    (edit_buf),
      .buf_nxt  (buf_nxt),
      .blink    (blink)
   );

   // buf_nxt equals edit_buf on ENTER, so one write path serves both modes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NREG; k++) reg_q[k] <= RST_VAL;
         sel    <= '0;
         commit <= 1'b0;
      end else begin
         if (reg_wr)  reg_q[sel] <= buf_nxt;
         if (sel_adv) sel <= sel_nxt;
         commit <= reg_wr;
      end
   end

   for (genvar k = 0; k < NREG; k++) begin : g_flat
      assign regs[k*WIDTH +: WIDTH] = reg_q[k];
   end

endmodule

// File: tb/tb_hex_entry_bank.sv
// Self-checking bench for hex_entry_bank (WIDTH=32, NREG=3); a plain
// array/arithmetic model of the operand bank predicts every key's effect.
module tb_hex_entry_bank;

   localparam int          W  = 32;
   localparam int          N  = 3;
   localparam int          ND = 8;
   localparam logic [31:0] RV = 32'h87654321;
`ifdef ENTRY_DIRECT_EN
   localparam bit DIRECT = 1'b1;
`else
   localparam bit DIRECT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          edit_en = 1'b0;
   logic          din_valid = 1'b0;
   logic [4:0]    din = '0;
   logic          readn;
   logic [N*W-1:0] regs;
   logic [1:0]    sel;
   logic [W-1:0]  edit_buf;
   logic [ND-1:0] blink;
   logic          commit;

   hex_entry_bank #(.WIDTH(W), .NREG(N), .RST_VAL(RV)) dut (
      .clk       (clk),
      .rst       (rst),
      .edit_en   (edit_en),
      .din_valid (din_valid),
      .din       (din),
      .readn     (readn),
      .regs      (regs),
      .sel       (sel),
      .edit_buf  (edit_buf),
      .blink     (blink),
      .commit    (commit)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_regs [N];
   logic [31:0] m_buf;
   int          m_cnt;
   int          m_sel;
   int          obs_low, obs_commit, obs_commit_at;

   task automatic model_reset();
      for (int k = 0; k < N; k++) m_regs[k] = RV;
      m_buf = RV;
      m_cnt = 0;
      m_sel = 0;
   endtask

   task automatic model_key(input logic [4:0] k, output int c);
      c = 0;
      if (k[4] == 1'b0) begin
         m_buf = (m_buf << 4) | 32'(k[3:0]);
         m_cnt = (m_cnt < ND) ? m_cnt + 1 : ND;
         if (DIRECT) begin m_regs[m_sel] = m_buf; c = 1; end
      end else begin
         case (int'(k[3:0]))
            0: begin
               m_buf = m_buf >> 4;
               m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
               if (DIRECT) begin m_regs[m_sel] = m_buf; c = 1; end
            end
            1: begin
               m_buf = 0;
               m_cnt = 0;
               if (DIRECT) begin m_regs[m_sel] = m_buf; c = 1; end
            end
            2: begin
               m_sel = (m_sel + 1) % N;
               m_buf = m_regs[m_sel];
               m_cnt = 0;
            end
            3: begin
               m_cnt = 0;
               if (!DIRECT) begin m_regs[m_sel] = m_buf; c = 1; end
            end
            default: ;
         endcase
      end
   endtask

   function automatic logic [ND-1:0] exp_blink(input int c);
      logic [ND:0] t;
      t = (9'd1 << c) - 9'd1;
      return t[ND-1:0];
   endfunction

   // Presents one key and records readn-low cycles and commit pulses, sampled on negedges.
   task automatic press(input logic [4:0] k, input int hold, input bit drop_en, input bit pre_held);
      int idx;
      idx = 0;
      obs_low = 0;
      obs_commit = 0;
      obs_commit_at = 0;
      if (!pre_held) begin
         @(negedge clk);
         din = k;
         din_valid = 1'b1;
      end
      for (int i = 1; i <= hold; i++) begin
         @(negedge clk);
         idx++;
         if (readn !== 1'b1) obs_low++;
         if (commit === 1'b1) begin
            obs_commit++;
            if (obs_commit_at == 0) obs_commit_at = idx;
         end
         if (i == 1 && drop_en) edit_en = 1'b0;
      end
      din_valid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         idx++;
         if (commit === 1'b1) begin
            obs_commit++;
            if (obs_commit_at == 0) obs_commit_at = idx;
         end
         if (readn === 1'b1) break;
         obs_low++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      model_reset();
      for (int k = 0; k < N; k++) begin
         checks++;
         if (regs[k*W +: W] !== RV) begin
            errors++;
            $display("FAIL reset_regs[%0d] got %h want %h", k, regs[k*W +: W], RV);
         end
      end
      checks++;
      if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel); end
      checks++;
      if (readn !== 1'b1) begin errors++; $display("FAIL reset_readn got %b want 1", readn); end
      checks++;
      if (blink !== 8'h00) begin errors++; $display("FAIL reset_blink got %h want 00", blink); end
      checks++;
      if (edit_buf !== RV) begin errors++; $display("FAIL reset_edit_buf got %h want %h", edit_buf, RV); end
      checks++;
      if (commit !== 1'b0) begin errors++; $display("FAIL reset_commit got %b want 0", commit); end
      rst = 1'b0;
      edit_en = 1'b1;
   endtask

   task automatic test_entry();
      logic [4:0] keys [6];
      int c;
      keys = '{5'h11, 5'h01, 5'h02, 5'h03, 5'h0A, 5'h13};
      for (int i = 0; i < 6; i++) begin
         model_key(keys[i], c);
         press(keys[i], 5, 1'b0, 1'b0);
         checks++;
         if (obs_low != 5) begin errors++; $display("FAIL entry_readn_low key%0d got %0d want 5", i, obs_low); end
         checks++;
         if (obs_commit != c) begin errors++; $display("FAIL entry_commit key%0d got %0d want %0d", i, obs_commit, c); end
      end
      checks++;
      if (regs[31:0] !== 32'h0000123A) begin errors++; $display("FAIL entry_reg0 got %h want 0000123A", regs[31:0]); end
      checks++;
      if (edit_buf !== 32'h0000123A) begin errors++; $display("FAIL entry_edit_buf got %h want 0000123A", edit_buf); end
      checks++;
      if (blink !== 8'h00) begin errors++; $display("FAIL entry_blink got %h want 00", blink); end
   endtask

   task automatic test_overflow();
      int c;
      model_key(5'h11, c);
      press(5'h11, 3, 1'b0, 1'b0);
      for (int d = 1; d <= 9; d++) begin
         model_key(5'(d), c);
         press(5'(d), 3, 1'b0, 1'b0);
      end
      checks++;
      if (edit_buf !== 32'h23456789) begin errors++; $display("FAIL ovf_edit_buf got %h want 23456789", edit_buf); end
      checks++;
      if (blink !== 8'hFF) begin errors++; $display("FAIL ovf_blink got %h want FF", blink); end
      model_key(5'h10, c);
      press(5'h10, 3, 1'b0, 1'b0);
      checks++;
      if (edit_buf !== 32'h02345678) begin errors++; $display("FAIL bksp_edit_buf got %h want 02345678", edit_buf); end
      checks++;
      if (blink !== 8'h7F) begin errors++; $display("FAIL bksp_blink got %h want 7F", blink); end
      checks++;
      if (regs[31:0] !== m_regs[0]) begin errors++; $display("FAIL ovf_reg0 got %h want %h", regs[31:0], m_regs[0]); end
   endtask

   task automatic test_next();
      int c;
      int want_sel [3];
      want_sel = '{1, 2, 0};
      for (int i = 0; i < 3; i++) begin
         model_key(5'h12, c);
         press(5'h12, 4, 1'b0, 1'b0);
         checks++;
         if (sel !== 2'(want_sel[i])) begin errors++; $display("FAIL next_sel step%0d got %0d want %0d", i, sel, want_sel[i]); end
         checks++;
         if (edit_buf !== m_regs[want_sel[i]]) begin
            errors++;
            $display("FAIL next_edit_buf step%0d got %h want %h", i, edit_buf, m_regs[want_sel[i]]);
         end
         checks++;
         if (blink !== 8'h00) begin errors++; $display("FAIL next_blink step%0d got %h want 00", i, blink); end
      end
   endtask

   task automatic test_edit_en();
      int c;
      edit_en = 1'b0;
      press(5'h0F, 4, 1'b0, 1'b0);
      checks++;
      if (obs_low != 0) begin errors++; $display("FAIL en_off_readn_low got %0d want 0", obs_low); end
      checks++;
      if (edit_buf !== m_buf) begin errors++; $display("FAIL en_off_edit_buf got %h want %h", edit_buf, m_buf); end
      edit_en = 1'b1;
      model_key(5'h0E, c);
      press(5'h0E, 4, 1'b1, 1'b0);
      edit_en = 1'b1;
      checks++;
      if (obs_low != 4) begin errors++; $display("FAIL en_drop_readn_low got %0d want 4", obs_low); end
      checks++;
      if (edit_buf !== m_buf) begin errors++; $display("FAIL en_drop_edit_buf got %h want %h", edit_buf, m_buf); end
   endtask

   task automatic test_reset_midkey();
      int c;
      @(negedge clk);
      din = 5'h07;
      din_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (readn !== 1'b1) begin errors++; $display("FAIL midrst_readn got %b want 1", readn); end
      checks++;
      if (edit_buf !== RV || sel !== 2'd0 || blink !== 8'h00 || commit !== 1'b0) begin
         errors++;
         $display("FAIL midrst_outputs got buf=%h sel=%0d blink=%h commit=%b want %h/0/00/0",
                  edit_buf, sel, blink, commit, RV);
      end
      checks++;
      if (regs !== {N{RV}}) begin errors++; $display("FAIL midrst_regs got %h want all %h", regs, RV); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      model_key(5'h07, c);
      press(5'h07, 4, 1'b0, 1'b1);
      checks++;
      if (obs_low != 4) begin errors++; $display("FAIL midrst_held_readn_low got %0d want 4", obs_low); end
      checks++;
      if (edit_buf !== m_buf) begin errors++; $display("FAIL midrst_held_edit_buf got %h want %h", edit_buf, m_buf); end
      checks++;
      if (blink !== exp_blink(m_cnt)) begin errors++; $display("FAIL midrst_held_blink got %h want %h", blink, exp_blink(m_cnt)); end
   endtask

   task automatic test_direct();
`ifdef ENTRY_DIRECT_EN
      int c;
      while (m_sel != 1) begin
         model_key(5'h12, c);
         press(5'h12, 3, 1'b0, 1'b0);
      end
      model_key(5'h11, c);
      press(5'h11, 3, 1'b0, 1'b0);
      model_key(5'h05, c);
      press(5'h05, 3, 1'b0, 1'b0);
      checks++;
      if (regs[W +: W] !== 32'h00000005) begin errors++; $display("FAIL direct_reg1 got %h want 00000005", regs[W +: W]); end
      checks++;
      if (obs_commit != 1 || obs_commit_at != 2) begin
         errors++;
         $display("FAIL direct_commit got count=%0d at=%0d want 1 at 2", obs_commit, obs_commit_at);
      end
`endif
   endtask

   task automatic test_random();
      int c, r, hold, exp_low;
      bit en, drop;
      logic [4:0] k;
      for (int n = 0; n < 120; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3, 4, 5: k = {1'b0, 4'($urandom_range(0, 15))};
            6: k = 5'h10;
            7: k = ($urandom_range(0, 1) == 1) ? 5'h11 : 5'h12;
            8: k = 5'h13;
            default: k = {1'b1, 4'($urandom_range(4, 15))};
         endcase
         hold = $urandom_range(2, 6);
         en = ($urandom_range(0, 9) != 0);
         drop = en && ($urandom_range(0, 6) == 0);
         edit_en = en;
         c = 0;
         if (en) model_key(k, c);
         exp_low = en ? hold : 0;
         press(k, hold, drop, 1'b0);
         edit_en = 1'b1;
         checks++;
         if (obs_low != exp_low) begin errors++; $display("FAIL rnd%0d_readn_low key=%h got %0d want %0d", n, k, obs_low, exp_low); end
         checks++;
         if (obs_commit != c || (c == 1 && obs_commit_at != 2)) begin
            errors++;
            $display("FAIL rnd%0d_commit key=%h got count=%0d at=%0d want %0d at 2", n, k, obs_commit, obs_commit_at, c);
         end
         checks++;
         if (edit_buf !== m_buf) begin errors++; $display("FAIL rnd%0d_edit_buf key=%h got %h want %h", n, k, edit_buf, m_buf); end
         checks++;
         if (blink !== exp_blink(m_cnt)) begin errors++; $display("FAIL rnd%0d_blink key=%h got %h want %h", n, k, blink, exp_blink(m_cnt)); end
         checks++;
         if (sel !== 2'(m_sel)) begin errors++; $display("FAIL rnd%0d_sel key=%h got %0d want %0d", n, k, sel, m_sel); end
         for (int j = 0; j < N; j++) begin
            checks++;
            if (regs[j*W +: W] !== m_regs[j]) begin
               errors++;
               $display("FAIL rnd%0d_reg%0d key=%h got %h want %h", n, j, k, regs[j*W +: W], m_regs[j]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_entry();
      test_overflow();
      test_next();
      test_edit_en();
      test_reset_midkey();
      test_direct();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog_timeout got running want finished");
      $fatal(1, "watchdog");
   end

endmodule
